// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte streams.
// A grant is held across a packet until its last byte, or until the owner idles for LOCK_TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 1024,
    localparam int IDX_W       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_send,
    output logic [7:0]           uart_send_data,
    input  logic                 uart_send_busy,
    output logic                 grant_active,
    output logic [IDX_W-1:0]     grant_id,
    output logic                 lock_timeout
);

    localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   N_WIDE   = (IDX_W + 1)'(NUM_REQ);
    localparam int unsigned      N_U      = NUM_REQ;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_START,
        WAIT_DONE,
        NEXT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] rr_ptr;
    logic [7:0]       buf_data;
    logic             buf_last;
    logic [CNT_W-1:0] cnt;

    logic [IDX_W-1:0] sel;
    logic             any_valid;
    logic [IDX_W:0]   scan;
    logic             owner_valid;
    logic [IDX_W-1:0] next_ptr;
    logic             cnt_expired;

    // Rotating-priority scan starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        sel       = rr_ptr;
        any_valid = 1'b0;
        scan      = '0;
        for (int unsigned i = 0; i < N_U; i++) begin
            scan = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
            if (scan >= N_WIDE) begin
                scan = scan - N_WIDE;
            end
            if (!any_valid && req_valid[scan[IDX_W-1:0]]) begin
                any_valid = 1'b1;
                sel       = scan[IDX_W-1:0];
            end
        end
    end

    assign owner_valid = req_valid[grant_id];
    assign next_ptr    = (grant_id == LAST_IDX) ? '0 : grant_id + IDX_W'(1);
    assign cnt_expired = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (any_valid) state_next = SEND;
            SEND:       if (!uart_send_busy) state_next = WAIT_START;
            WAIT_START: if (uart_send_busy) state_next = WAIT_DONE;
            WAIT_DONE:  if (!uart_send_busy) state_next = buf_last ? IDLE : NEXT;
            NEXT: begin
                if (owner_valid) begin
                    state_next = SEND;
                end else if (cnt_expired) begin
                    state_next = IDLE;
                end
            end
            default:    state_next = IDLE;
        endcase
    end

    // Combinational outputs are gated by rst so nothing is accepted or sent during reset.
    always_comb begin
        req_ready      = '0;
        uart_send      = 1'b0;
        uart_send_data = '0;
        lock_timeout   = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (any_valid) req_ready[sel] = 1'b1;
                end
                SEND: begin
                    if (!uart_send_busy) begin
                        uart_send      = 1'b1;
                        uart_send_data = buf_data;
                    end
                end
                NEXT: begin
                    req_ready[grant_id] = owner_valid;
                    lock_timeout        = !owner_valid && cnt_expired;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            cnt          <= '0;
            buf_data     <= '0;
            buf_last     <= 1'b0;
            grant_id     <= '0;
            grant_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        buf_data     <= req_data[{sel, 3'b000} +: 8];
                        buf_last     <= req_last[sel];
                        grant_id     <= sel;
                        grant_active <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_send_busy) begin
                        if (buf_last) begin
                            rr_ptr       <= next_ptr;
                            grant_active <= 1'b0;
                        end else begin
                            cnt <= '0;
                        end
                    end
                end
                NEXT: begin
                    if (owner_valid) begin
                        buf_data <= req_data[{grant_id, 3'b000} +: 8];
                        buf_last <= req_last[grant_id];
                        cnt      <= '0;
                    end else if (cnt_expired) begin
                        rr_ptr       <= next_ptr;
                        grant_active <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
